brick_field: RTL and testbench

Owns the 12x16 playfield occupancy map (bricks plus paddle) that the ball-movement stage reads as its `data` bus. The map is indexed `row*16+col`.
On each ball step pulse, the block snapshots the ball position and direction, clears the bricks the ball is about to strike, and updates the score and brick count. It also detects loss (ball in the paddle row) and win (no bricks left).
It sits directly upstream of ball movement, and closes the loop with ball movement's outputs.

---
 rtl/brick_field.sv | 208 ++++++++++++++++++++
 tb/tb_brick_field.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/brick_field.sv
// Playfield occupancy map for the brick game: bricks in rows 0..10, paddle in row 11.
// Each ball step is resolved in three single-cycle scans (vertical, horizontal,
// diagonal) that clear at most one brick each and keep score/brick count in step.
module brick_field #(
    parameter int BRICK_TOP    = 1,
    parameter int BRICK_ROWS   = 3,
    parameter int PADDLE_WIDTH = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic         ball_step,
    input  logic [3:0]   Ball_rowIndex,
    input  logic [3:0]   Ball_colIndex,
    input  logic [1:0]   Ball_direction,
    input  logic [3:0]   paddle_col,
    output logic [191:0] data,
    output logic [7:0]   score,
    output logic [7:0]   bricks_left,
    output logic         busy,
    output logic         game_over,
    output logic         win
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PLAY,
        ST_SCAN_V,
        ST_SCAN_H,
        ST_SCAN_D,
        ST_LOST,
        ST_WIN
    } state_t;

    localparam logic [3:0]  PADDLE_MAX  = 4'(16 - PADDLE_WIDTH);
    localparam logic [15:0] PADDLE_ONES = 16'((33'd1 << PADDLE_WIDTH) - 33'd1);
    localparam logic [7:0]  BRICK_COUNT = 8'(BRICK_ROWS * 16);

    // Rows BRICK_TOP..BRICK_TOP+BRICK_ROWS-1 fully populated, everything else empty.
    function automatic logic [175:0] brickMask();
        logic [175:0] m;
        m = '0;
        for (int r = 0; r < 11; r++) begin
            if (r >= BRICK_TOP && r < BRICK_TOP + BRICK_ROWS) begin
                m[r*16 +: 16] = 16'hFFFF;
            end
        end
        return m;
    endfunction

    localparam logic [175:0] BRICK_MASK = brickMask();

    state_t        state_q, state_d;
    logic [175:0]  field_q, field_d;
    logic [15:0]   paddle_q;
    logic [7:0]    score_q, score_d;
    logic [7:0]    left_q, left_d;
    logic [3:0]    row_q, row_d;
    logic [3:0]    col_q, col_d;
    logic [1:0]    dir_q, dir_d;
    logic          hitV_q, hitV_d;
    logic          hitH_q, hitH_d;
    logic          busy_q, gameOver_q, win_q;

    logic [3:0]    paddleCol;
    logic [15:0]   paddleMask;
    logic [4:0]    rowAdj, colAdj;
    logic [4:0]    tRow, tCol;
    logic [7:0]    tIdx;
    logic          tLegal, tSet;
    logic          clearHit;
    logic [7:0]    leftAfter;

    // Paddle mask from the clamped paddle column so the paddle never runs off the right edge.
    always_comb begin
        paddleCol  = (paddle_col > PADDLE_MAX) ? PADDLE_MAX : paddle_col;
        paddleMask = PADDLE_ONES << paddleCol;
    end

    // The paddle row follows paddle_col every cycle, reset or not, so it has no reset branch.
    always_ff @(posedge clock) begin
        paddle_q <= paddleMask;
    end

    // Pick the cell probed by the current scan; 5-bit arithmetic exposes 4-bit wraps as out of range.
    always_comb begin
        rowAdj = dir_q[1] ? ({1'b0, row_q} + 5'd1) : ({1'b0, row_q} - 5'd1);
        colAdj = dir_q[0] ? ({1'b0, col_q} + 5'd1) : ({1'b0, col_q} - 5'd1);
        tRow   = rowAdj;
        tCol   = colAdj;
        case (state_q)
            ST_SCAN_V: begin
                tRow = rowAdj;
                tCol = {1'b0, col_q};
            end
            ST_SCAN_H: begin
                tRow = {1'b0, row_q};
                tCol = colAdj;
            end
            default: begin
                tRow = rowAdj;
                tCol = colAdj;
            end
        endcase
        tLegal = (tRow < 5'd11) && (tCol < 5'd16);
        tIdx   = {tRow[3:0], tCol[3:0]};
        tSet   = tLegal && field_q[tIdx];
    end

    // Next-state logic: start/reload, step latch, the three scans and their counter updates.
    always_comb begin
        state_d   = state_q;
        field_d   = field_q;
        score_d   = score_q;
        left_d    = left_q;
        row_d     = row_q;
        col_d     = col_q;
        dir_d     = dir_q;
        hitV_d    = hitV_q;
        hitH_d    = hitH_q;
        clearHit  = 1'b0;
        leftAfter = left_q;

        case (state_q)
            ST_IDLE, ST_LOST, ST_WIN: begin
                if (start) begin
                    field_d = BRICK_MASK;
                    left_d  = BRICK_COUNT;
                    score_d = 8'd0;
                    state_d = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (ball_step) begin
                    row_d   = Ball_rowIndex;
                    col_d   = Ball_colIndex;
                    dir_d   = Ball_direction;
                    hitV_d  = 1'b0;
                    hitH_d  = 1'b0;
                    state_d = (Ball_rowIndex == 4'd11) ? ST_LOST : ST_SCAN_V;
                end
            end
            ST_SCAN_V: begin
                clearHit = tSet;
                hitV_d   = tSet;
                state_d  = ST_SCAN_H;
            end
            ST_SCAN_H: begin
                clearHit = tSet;
                hitH_d   = tSet;
                state_d  = ST_SCAN_D;
            end
            ST_SCAN_D: begin
                clearHit  = tSet && !hitV_q && !hitH_q;
                leftAfter = clearHit ? (left_q - 8'd1) : left_q;
                state_d   = (leftAfter == 8'd0) ? ST_WIN : ST_PLAY;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (clearHit) begin
            field_d[tIdx] = 1'b0;
            left_d        = left_q - 8'd1;
            score_d       = (score_q == 8'hFF) ? score_q : (score_q + 8'd1);
        end
    end

    // State, map, counters and registered status flags; reset wipes any partial scan.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            field_q    <= '0;
            score_q    <= 8'd0;
            left_q     <= 8'd0;
            row_q      <= 4'd0;
            col_q      <= 4'd0;
            dir_q      <= 2'd0;
            hitV_q     <= 1'b0;
            hitH_q     <= 1'b0;
            busy_q     <= 1'b0;
            gameOver_q <= 1'b0;
            win_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            field_q    <= field_d;
            score_q    <= score_d;
            left_q     <= left_d;
            row_q      <= row_d;
            col_q      <= col_d;
            dir_q      <= dir_d;
            hitV_q     <= hitV_d;
            hitH_q     <= hitH_d;
            busy_q     <= (state_d == ST_SCAN_V) || (state_d == ST_SCAN_H) || (state_d == ST_SCAN_D);
            gameOver_q <= (state_d == ST_LOST);
            win_q      <= (state_d == ST_WIN);
        end
    end

    assign data        = {paddle_q, field_q};
    assign score       = score_q;
    assign bricks_left = left_q;
    assign busy        = busy_q;
    assign game_over   = gameOver_q;
    assign win         = win_q;

endmodule

// File: tb/tb_brick_field.sv
// Randomized and directed bench for brick_field against a cell-grid reference model.
module tb_brick_field;

    localparam int BT = 1;
    localparam int BR = 3;
    localparam int PW = 4;

    localparam int M_IDLE = 0;
    localparam int M_PLAY = 1;
    localparam int M_LOST = 2;
    localparam int M_WON  = 3;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic         ball_step = 1'b0;
    logic [3:0]   Ball_rowIndex = '0;
    logic [3:0]   Ball_colIndex = '0;
    logic [1:0]   Ball_direction = '0;
    logic [3:0]   paddle_col = '0;
    logic [191:0] data;
    logic [7:0]   score;
    logic [7:0]   bricks_left;
    logic         busy;
    logic         game_over;
    logic         win;

    int assertCount = 0;
    int failCount   = 0;

    bit occ [11][16];
    int mScore;
    int mLeft;
    int mMode;

    brick_field #(
        .BRICK_TOP   (BT),
        .BRICK_ROWS  (BR),
        .PADDLE_WIDTH(PW)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .ball_step     (ball_step),
        .Ball_rowIndex (Ball_rowIndex),
        .Ball_colIndex (Ball_colIndex),
        .Ball_direction(Ball_direction),
        .paddle_col    (paddle_col),
        .data          (data),
        .score         (score),
        .bricks_left   (bricks_left),
        .busy          (busy),
        .game_over     (game_over),
        .win           (win)
    );

    // Free-running system clock.
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        assertCount++;
        if (obs !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input int r, input int c, input int d);
        Ball_rowIndex  = 4'(r);
        Ball_colIndex  = 4'(c);
        Ball_direction = 2'(d);
    endtask

    function automatic bit legalCell(input int r, input int c);
        return (r >= 0) && (r <= 10) && (c >= 0) && (c <= 15);
    endfunction

    function automatic void modelReset();
        for (int r = 0; r < 11; r++)
            for (int c = 0; c < 16; c++)
                occ[r][c] = 1'b0;
        mScore = 0;
        mLeft  = 0;
        mMode  = M_IDLE;
    endfunction

    function automatic void modelStart();
        if (mMode == M_PLAY) return;
        for (int r = 0; r < 11; r++)
            for (int c = 0; c < 16; c++)
                occ[r][c] = (r >= BT && r < BT + BR);
        mScore = 0;
        mLeft  = BR * 16;
        mMode  = M_PLAY;
    endfunction

    function automatic void modelClear(input int r, input int c);
        occ[r][c] = 1'b0;
        mLeft--;
        if (mScore < 255) mScore++;
    endfunction

    // Whole-step outcome in one go: vertical, then horizontal, then diagonal only if neither hit.
    function automatic void modelStep(input int r, input int c, input int d);
        int  dv, dh;
        bit  hv, hh;
        if (mMode != M_PLAY) return;
        if (r == 11) begin
            mMode = M_LOST;
            return;
        end
        dv = d[1] ? 1 : -1;
        dh = d[0] ? 1 : -1;
        hv = legalCell(r + dv, c) && occ[r + dv][c];
        if (hv) modelClear(r + dv, c);
        hh = legalCell(r, c + dh) && occ[r][c + dh];
        if (hh) modelClear(r, c + dh);
        if (!hv && !hh && legalCell(r + dv, c + dh) && occ[r + dv][c + dh])
            modelClear(r + dv, c + dh);
        if (mLeft == 0) mMode = M_WON;
    endfunction

    function automatic logic [191:0] expData();
        logic [191:0] v;
        int pc;
        v = '0;
        for (int r = 0; r < 11; r++)
            for (int c = 0; c < 16; c++)
                v[r*16 + c] = occ[r][c];
        pc = (int'(paddle_col) > 16 - PW) ? 16 - PW : int'(paddle_col);
        for (int k = 0; k < PW; k++) v[176 + pc + k] = 1'b1;
        return v;
    endfunction

    task automatic compareAll(input string tag);
        checkOutput({tag, "_data"},  data, expData());
        checkOutput({tag, "_score"}, 192'(score), 192'(mScore));
        checkOutput({tag, "_left"},  192'(bricks_left), 192'(mLeft));
        checkOutput({tag, "_busy"},  192'(busy), 192'(0));
        checkOutput({tag, "_over"},  192'(game_over), 192'(mMode == M_LOST));
        checkOutput({tag, "_win"},   192'(win), 192'(mMode == M_WON));
    endtask

    task automatic doReset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        modelReset();
    endtask

    task automatic doStart(input string tag);
        start = 1'b1;
        tick();
        start = 1'b0;
        modelStart();
        compareAll(tag);
    endtask

    // One ball step; scans are tracked through busy, with optional noise pulses while busy.
    task automatic doStep(input string tag, input int r, input int c, input int d, input bit noise);
        bit scans;
        scans = (mMode == M_PLAY) && (r != 11);
        applyStimulus(r, c, d);
        ball_step = 1'b1;
        tick();
        ball_step = 1'b0;
        if (scans) begin
            checkOutput({tag, "_busy1"}, 192'(busy), 192'(1));
            if (noise) begin
                ball_step = 1'b1;
                start     = 1'b1;
                applyStimulus($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 3));
            end
            tick();
            ball_step = 1'b0;
            start     = 1'b0;
            checkOutput({tag, "_busy2"}, 192'(busy), 192'(1));
            tick();
            checkOutput({tag, "_busy3"}, 192'(busy), 192'(1));
            tick();
        end
        modelStep(r, c, d);
        compareAll(tag);
    endtask

    initial begin
        // Reset with paddle at column 0.
        paddle_col = 4'd0;
        doReset();
        compareAll("reset");
        checkOutput("reset_paddle", data, 192'hF << 176);

        // Step ignored in IDLE, start loads rows 1..3.
        doStep("idle_step", 4, 5, 0, 1'b0);
        doStart("start");
        checkOutput("start_bits", data[175:0], 176'hFFFF_FFFF_FFFF << 16);
        paddle_col = 4'd15;
        tick();
        checkOutput("paddle_clamp", 192'(data[191:176]), 192'h000F000 >> 12 << 12);
        compareAll("paddle15");

        // Single vertical hit with mid-scan observation.
        paddle_col = 4'd3;
        applyStimulus(4, 5, 0);
        ball_step = 1'b1;
        tick();
        ball_step = 1'b0;
        tick();
        checkOutput("t3_bit53_mid", 192'(data[53]), 192'(0));
        checkOutput("t3_score_mid", 192'(score), 192'(1));
        tick();
        tick();
        modelStep(4, 5, 0);
        compareAll("t3_final");

        // Corner and diagonal cases.
        doReset();
        doStart("t4_startA");
        doStep("t4_edge", 4, 0, 0, 1'b0);
        checkOutput("t4_bit48", 192'(data[48]), 192'(0));
        doStep("t4_corner", 4, 6, 1, 1'b0);
        checkOutput("t4_keep55", 192'(data[55]), 192'(1));
        doStep("t4_diag", 4, 6, 1, 1'b0);
        checkOutput("t4_clear55", 192'(data[55]), 192'(0));

        // Start in PLAY is ignored; ball in paddle row loses; LOST ignores steps; start reloads.
        start = 1'b1;
        tick();
        start = 1'b0;
        compareAll("play_start");
        doStep("t5_lose", 11, 3, 2, 1'b0);
        doStep("t5_ignored", 4, 5, 0, 1'b0);
        doStart("t5_restart");

        // Clear every brick one per step, bottom row first, ending in WIN.
        for (int r = BT + BR - 1; r >= BT; r--)
            for (int c = 0; c < 16; c++)
                doStep("t6_sweep", r + 1, c, 0, 1'b0);
        checkOutput("t6_win", 192'(win), 192'(1));
        checkOutput("t6_score", 192'(score), 192'(BR * 16));
        doStep("t6_won_ignored", 4, 5, 0, 1'b0);

        // Reset landing on SCAN_H discards the in-flight step.
        doStart("t6b_start");
        applyStimulus(4, 5, 0);
        ball_step = 1'b1;
        tick();
        ball_step = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        modelReset();
        compareAll("t6b_reset");

        // Randomized play against the model.
        for (int i = 0; i < 250; i++) begin
            paddle_col = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 59) == 0) begin
                doReset();
                compareAll("rnd_reset");
            end else if (mMode != M_PLAY && $urandom_range(0, 3) != 0) begin
                doStart("rnd_start");
            end else begin
                int r;
                r = ($urandom_range(0, 11) == 0) ? 11 : $urandom_range(0, 6);
                if ($urandom_range(0, 15) == 0) r = $urandom_range(12, 15);
                doStep("rnd_step", r, $urandom_range(0, 15), $urandom_range(0, 3),
                       1'($urandom_range(0, 1)));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
